// File: rtl/shift_nbit_iter.sv
// Iterative multi-mode shifter: SLL/SRL/SRA/ROR applied as log-shifter
// stages over several cycles, with valid/ready handshakes on both sides.
module shift_nbit_iter #(
  parameter int WIDTH            = 32,
  parameter int SHIFT_WIDTH      = 5,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       A,
  input  logic [SHIFT_WIDTH-1:0] B,
  input  logic [1:0]             OP,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       Y,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int KW = $clog2(SHIFT_WIDTH + STAGES_PER_CYCLE + 1);

  state_t                 state;
  logic [WIDTH-1:0]       data;
  logic [WIDTH-1:0]       data_nx;
  logic [SHIFT_WIDTH-1:0] amt;
  logic [1:0]             mode;
  logic [KW-1:0]          k;
  logic                   last;
  int                     idx;

  // One log-shifter stage of 2^i; oversized shifts saturate naturally.
  function automatic logic [WIDTH-1:0] stage(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input int               i
  );
    logic [63:0]        s;
    logic [2*WIDTH-1:0] dd;
    int                 r;
    s  = 64'd1 << i;
    r  = int'(s % 64'(WIDTH));
    dd = {d, d} >> r;
    case (m)
      2'b00:   stage = d << s;
      2'b01:   stage = d >> s;
      2'b10:   stage = $signed(d) >>> s;
      default: stage = dd[WIDTH-1:0];
    endcase
  endfunction

  always_comb begin
    data_nx = data;
    idx     = 0;
    for (int j = 0; j < STAGES_PER_CYCLE; j++) begin
      idx = int'(k) + j;
      if (idx < SHIFT_WIDTH && amt[idx])
        data_nx = stage(data_nx, mode, idx);
    end
  end

  assign last = (int'(k) + STAGES_PER_CYCLE) >= SHIFT_WIDTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      amt   <= '0;
      mode  <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= A;
            amt   <= B;
            mode  <= OP;
            k     <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          data <= data_nx;
          k    <= k + KW'(STAGES_PER_CYCLE);
          if (last)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign Y         = data;

endmodule

// File: tb/tb_shift_nbit_iter.sv
// Randomised and directed checks of shift_nbit_iter against an
// arithmetic reference, across three parameter sets.
module tb_shift_nbit_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // dut0: defaults
  logic        iv0, rdy0, ov0, ordy0, bz0;
  logic [31:0] a0, y0;
  logic [4:0]  b0;
  logic [1:0]  op0;
  // dut1: two stages per cycle
  logic        iv1, rdy1, ov1, ordy1, bz1;
  logic [31:0] a1, y1;
  logic [4:0]  b1;
  logic [1:0]  op1;
  // dut2: 8-bit operand, 4-bit amount
  logic        iv2, rdy2, ov2, ordy2, bz2;
  logic [7:0]  a2, y2;
  logic [3:0]  b2;
  logic [1:0]  op2;

  shift_nbit_iter u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0),
    .A(a0), .B(b0), .OP(op0), .out_valid(ov0),
    .out_ready(ordy0), .Y(y0), .busy(bz0)
  );

  shift_nbit_iter #(.STAGES_PER_CYCLE(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
    .A(a1), .B(b1), .OP(op1), .out_valid(ov1),
    .out_ready(ordy1), .Y(y1), .busy(bz1)
  );

  shift_nbit_iter #(.WIDTH(8), .SHIFT_WIDTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2),
    .A(a2), .B(b2), .OP(op2), .out_valid(ov2),
    .out_ready(ordy2), .Y(y2), .busy(bz2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: whole-amount shift in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] a,
    input int b, input logic [1:0] op, input int w);
    logic [63:0] mask, av, ext, res;
    int r;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, a} & mask;
    ext  = av[w-1] ? (av | ~mask) : av;
    r    = b % w;
    case (op)
      2'b00:   res = av << b;
      2'b01:   res = av >> b;
      2'b10:   res = $signed(ext) >>> b;
      default: res = (av >> r) | (av << (w - r));
    endcase
    return res[31:0] & mask[31:0];
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] a,
                       input logic [4:0] b, input logic [1:0] op);
    case (sel)
      0: begin iv0 = v; a0 = a; b0 = b; op0 = op; end
      1: begin iv1 = v; a1 = a; b1 = b; op1 = op; end
      default: begin iv2 = v; a2 = a[7:0]; b2 = b[3:0]; op2 = op; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic v);
    case (sel)
      0: ordy0 = v;
      1: ordy1 = v;
      default: ordy2 = v;
    endcase
  endtask

  function automatic logic get_ov(input int sel);
    return sel == 0 ? ov0 : sel == 1 ? ov1 : ov2;
  endfunction

  function automatic logic get_rdy(input int sel);
    return sel == 0 ? rdy0 : sel == 1 ? rdy1 : rdy2;
  endfunction

  function automatic logic [31:0] get_y(input int sel);
    return sel == 0 ? y0 : sel == 1 ? y1 : {24'd0, y2};
  endfunction

  // Issue one op, wait for the result, complete the output handshake.
  task automatic run_op(input int sel, input logic [31:0] a,
    input logic [4:0] b, input logic [1:0] op,
    output logic [31:0] y, output int lat);
    @(negedge clk);
    if (!get_rdy(sel)) check("in_ready_before_op", 32'd0, 32'd1);
    drive(sel, 1'b1, a, b, op);
    @(negedge clk);
    drive(sel, 1'b0, a, b, op);
    lat = 0;
    while (!get_ov(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!get_ov(sel)) check("result_timeout", 32'd0, 32'd1);
    y = get_y(sel);
    set_ordy(sel, 1'b1);
    @(negedge clk);
    set_ordy(sel, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] y, yh, a;
    logic [4:0]  b;
    logic [1:0]  op;
    int          lat, n;

    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    drive(2, 1'b0, 0, 0, 0);
    ordy0 = 0; ordy1 = 0; ordy2 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, rdy0}, 1);
    check("rst_out_valid", {31'd0, ov0}, 0);
    check("rst_busy", {31'd0, bz0}, 0);
    check("rst_y", y0, 0);
    check("rst_y_spc2", y1, 0);
    check("rst_y_w8", {24'd0, y2}, 0);

    run_op(0, 32'h8000_0000, 4, 2'b10, y, lat);
    check("sra_lat", lat, 5);
    check("sra_y", y, 32'hF800_0000);
    run_op(0, 32'h8000_0000, 4, 2'b01, y, lat);
    check("srl_y", y, 32'h0800_0000);
    run_op(0, 32'h0000_0001, 31, 2'b00, y, lat);
    check("sll31_y", y, 32'h8000_0000);
    run_op(0, 32'h0000_0001, 1, 2'b11, y, lat);
    check("ror1_y", y, 32'h8000_0000);
    run_op(0, 32'h1234_5678, 8, 2'b11, y, lat);
    check("ror8_y", y, 32'h7812_3456);

    run_op(1, 32'hFFFF_FF00, 0, 2'b10, y, lat);
    check("spc2_b0_lat", lat, 3);
    check("spc2_b0_y", y, 32'hFFFF_FF00);
    run_op(1, 32'hFFFF_FF00, 31, 2'b10, y, lat);
    check("spc2_sra31_y", y, 32'hFFFF_FFFF);

    // Backpressure with an ignored in_valid pulse during DONE.
    @(negedge clk);
    drive(0, 1'b1, 32'hA5A5_0000, 4, 2'b01);
    @(negedge clk);
    drive(0, 1'b0, 32'hA5A5_0000, 4, 2'b01);
    n = 0;
    while (!ov0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_lat", n, 5);
    yh = ref_shift(32'hA5A5_0000, 4, 2'b01, 32);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) drive(0, 1'b1, 32'h1234_5678, 1, 2'b00);
      else drive(0, 1'b0, 32'h1234_5678, 1, 2'b00);
      @(negedge clk);
      check("bp_y_stable", y0, yh);
      check("bp_out_valid", {31'd0, ov0}, 1);
      check("bp_in_ready", {31'd0, rdy0}, 0);
    end
    drive(0, 1'b0, 0, 0, 0);
    ordy0 = 1'b1;
    @(negedge clk);
    ordy0 = 1'b0;
    check("bp_release_in_ready", {31'd0, rdy0}, 1);
    check("bp_release_out_valid", {31'd0, ov0}, 0);
    repeat (8) begin
      @(negedge clk);
      check("bp_pulse_ignored", {30'd0, ov0, bz0}, 0);
    end

    // Reset in the second SHIFT cycle.
    @(negedge clk);
    drive(0, 1'b1, 32'hDEAD_BEEF, 3, 2'b10);
    @(negedge clk);
    drive(0, 1'b0, 32'hDEAD_BEEF, 3, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, rdy0}, 1);
    check("midrst_out_valid", {31'd0, ov0}, 0);
    check("midrst_busy", {31'd0, bz0}, 0);
    check("midrst_y", y0, 0);
    run_op(0, 32'h0000_0010, 4, 2'b01, y, lat);
    check("post_rst_lat", lat, 5);
    check("post_rst_y", y, 32'h0000_0001);

    for (int i = 0; i < 30; i++) begin
      a  = $urandom;
      b  = 5'($urandom_range(31));
      op = 2'($urandom_range(3));
      run_op(0, a, b, op, y, lat);
      check("rand32_y", y, ref_shift(a, int'(b), op, 32));
      check("rand32_lat", lat, 5);
      run_op(1, a, b, op, y, lat);
      check("rand_spc2_y", y, ref_shift(a, int'(b), op, 32));
      check("rand_spc2_lat", lat, 3);
    end

    for (int o = 0; o < 4; o++) begin
      for (int bb = 0; bb < 16; bb++) begin
        for (int t = 0; t < 16; t++) begin
          a = t == 0 ? 32'h80 : t == 1 ? 32'hFF : 32'($urandom_range(255));
          run_op(2, a, 5'(bb), 2'(o), y, lat);
          check("w8_y", y, ref_shift(a, bb, 2'(o), 8));
          check("w8_lat", lat, 4);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
